// File: rtl/instr_encoder.sv
// instr_encoder: packs abstract RV32I operations (R-type, lw, sw, beq) into
// 32-bit instruction words and streams them out through a 2-entry FIFO.
// Illegal immediates are rejected at accept and only counted.
module instr_encoder (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_op,
    input  logic [4:0]         in_rd,
    input  logic [4:0]         in_rs1,
    input  logic [4:0]         in_rs2,
    input  logic [2:0]         in_funct3,
    input  logic [6:0]         in_funct7,
    input  logic signed [12:0] in_imm,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_instr,
    output logic [15:0]        emit_count,
    output logic [7:0]         err_count,
    output logic               err_sticky
);

    localparam logic [1:0] OP_R   = 2'b00;
    localparam logic [1:0] OP_LW  = 2'b01;
    localparam logic [1:0] OP_SW  = 2'b10;
    localparam logic [1:0] OP_BEQ = 2'b11;

    localparam logic [6:0] OPC_R    = 7'b0110011;
    localparam logic [6:0] OPC_LOAD = 7'b0000011;
    localparam logic [6:0] OPC_STOR = 7'b0100011;
    localparam logic [6:0] OPC_BR   = 7'b1100011;

    // Pack one operation into its RV32I word; fields unused by the op are dropped.
    function automatic logic [31:0] encode(
        input logic [1:0]         op,
        input logic [4:0]         rd,
        input logic [4:0]         rs1,
        input logic [4:0]         rs2,
        input logic [2:0]         f3,
        input logic [6:0]         f7,
        input logic signed [12:0] imm
    );
        logic [31:0] w;
        case (op)
            OP_R:    w = {f7, rs2, rs1, f3, rd, OPC_R};
            OP_LW:   w = {imm[11:0], rs1, 3'b010, rd, OPC_LOAD};
            OP_SW:   w = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OPC_STOR};
            default: w = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], OPC_BR};
        endcase
        return w;
    endfunction

    // lw/sw offsets must fit 12 signed bits; branch offsets must be even.
    function automatic logic is_reject(
        input logic [1:0]         op,
        input logic signed [12:0] imm
    );
        logic r;
        case (op)
            OP_LW, OP_SW: r = (imm[12] != imm[11]);
            OP_BEQ:       r = imm[0];
            default:      r = 1'b0;
        endcase
        return r;
    endfunction

    logic [1:0]  count_q, count_d;
    logic [31:0] mem0_q, mem0_d;      // FIFO head
    logic [31:0] mem1_q, mem1_d;      // second entry
    logic [15:0] emit_count_q, emit_count_d;
    logic [7:0]  err_count_q, err_count_d;
    logic        err_sticky_q, err_sticky_d;

    logic        accept;
    logic        reject;
    logic        push;
    logic        pop;
    logic [31:0] word;

    // Ready/valid come only from registered occupancy, never from out_ready.
    assign in_ready   = (count_q != 2'd2);
    assign out_valid  = (count_q != 2'd0);
    assign out_instr  = out_valid ? mem0_q : 32'h0;
    assign emit_count = emit_count_q;
    assign err_count  = err_count_q;
    assign err_sticky = err_sticky_q;

    // Handshake decode, FIFO next-state and counter updates.
    always_comb begin
        accept       = in_valid && in_ready;
        reject       = is_reject(in_op, in_imm);
        push         = accept && !reject;
        pop          = out_valid && out_ready;
        word         = encode(in_op, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);

        count_d      = count_q;
        mem0_d       = mem0_q;
        mem1_d       = mem1_q;
        emit_count_d = emit_count_q;
        err_count_d  = err_count_q;
        err_sticky_d = err_sticky_q;

        // Pop shifts the second entry forward; push lands in the first free
        // slot as seen after the pop.
        if (pop) begin
            mem0_d = mem1_q;
        end
        if (push) begin
            if (count_q == 2'd1 && !pop) begin
                mem1_d = word;
            end else begin
                mem0_d = word;
            end
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        if (pop) begin
            emit_count_d = emit_count_q + 16'd1;
        end
        if (accept && reject) begin
            err_sticky_d = 1'b1;
            if (err_count_q != 8'hFF) begin
                err_count_d = err_count_q + 8'd1;
            end
        end
    end

    // Control state: occupancy and counters, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q      <= 2'd0;
            emit_count_q <= 16'd0;
            err_count_q  <= 8'd0;
            err_sticky_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            emit_count_q <= emit_count_d;
            err_count_q  <= err_count_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    // FIFO storage; contents are masked by occupancy so no reset is needed.
    always_ff @(posedge clk) begin
        mem0_q <= mem0_d;
        mem1_q <= mem1_d;
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed, table-driven bench for instr_encoder with hand-computed words.
module tb_instr_encoder;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [12:0] imm;
        logic        rej;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [12:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [15:0] emit_count;
    logic [7:0]  err_count;
    logic        err_sticky;

    int checks = 0;
    int failures = 0;
    int exp_emit = 0;
    int exp_err = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    instr_encoder dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .emit_count(emit_count), .err_count(err_count), .err_sticky(err_sticky)
    );

    function automatic vec_t mk(input string nm, input logic [1:0] op, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [12:0] imm, input logic rej,
                                input logic [31:0] exp);
        vec_t v;
        v.name = nm; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.f3 = f3; v.f7 = f7; v.imm = imm; v.rej = rej; v.exp = exp;
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        in_op = v.op; in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2;
        in_funct3 = v.f3; in_funct7 = v.f7; in_imm = v.imm;
        in_valid = 1'b1;
    endtask

    initial begin
        vec_t w1, w2, w3;
        logic [31:0] expq[3];
        int idx;
        logic acc;

        // Table: accepted words and rejected ops; junk in unused fields.
        vecs.push_back(mk("r_add",    2'b00, 5'd3,  5'd1,  5'd2,  3'd0, 7'h00, 13'h1555, 1'b0, 32'h002081B3));
        vecs.push_back(mk("r_sub",    2'b00, 5'd1,  5'd2,  5'd3,  3'd0, 7'h20, 13'h0000, 1'b0, 32'h403100B3));
        vecs.push_back(mk("lw_neg4",  2'b01, 5'd2,  5'd10, 5'd31, 3'd7, 7'h7F, 13'h1FFC, 1'b0, 32'hFFC52103));
        vecs.push_back(mk("lw_2047",  2'b01, 5'd1,  5'd0,  5'd0,  3'd0, 7'h00, 13'h07FF, 1'b0, 32'h7FF02083));
        vecs.push_back(mk("lw_m2048", 2'b01, 5'd1,  5'd0,  5'd0,  3'd0, 7'h00, 13'h1800, 1'b0, 32'h80002083));
        vecs.push_back(mk("sw_neg1",  2'b10, 5'd31, 5'd4,  5'd3,  3'd5, 7'h55, 13'h1FFF, 1'b0, 32'hFE322FA3));
        vecs.push_back(mk("beq_neg8", 2'b11, 5'd31, 5'd1,  5'd2,  3'd7, 7'h7F, 13'h1FF8, 1'b0, 32'hFE208CE3));
        vecs.push_back(mk("beq_4094", 2'b11, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 13'h0FFE, 1'b0, 32'h7E000FE3));
        vecs.push_back(mk("beq_m4096",2'b11, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 13'h1000, 1'b0, 32'h80000063));
        vecs.push_back(mk("sw_rej",   2'b10, 5'd0,  5'd1,  5'd2,  3'd0, 7'h00, 13'h17FF, 1'b1, 32'h0));
        vecs.push_back(mk("beq_rej1", 2'b11, 5'd0,  5'd1,  5'd2,  3'd0, 7'h00, 13'h0001, 1'b1, 32'h0));

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_op = 2'b00; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_funct3 = '0; in_funct7 = '0; in_imm = '0;
        tick; tick;
        rst = 1'b0;

        // Reset state
        chk("rst_in_ready",  32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_emit",      32'(emit_count), 32'd0);
        chk("rst_err",       32'(err_count), 32'd0);
        chk("rst_sticky",    32'(err_sticky), 32'd0);

        // lw then sw back to back with consumer always ready
        out_ready = 1'b1;
        drive(mk("lw", 2'b01, 5'd5, 5'd1, 5'd0, 3'd0, 7'h00, 13'h0008, 1'b0, 32'h0));
        tick;
        chk("seq_lw_valid", 32'(out_valid), 32'd1);
        chk("seq_lw_word", out_instr, 32'h0080A283);
        drive(mk("sw", 2'b10, 5'd0, 5'd2, 5'd5, 3'd0, 7'h00, 13'h000C, 1'b0, 32'h0));
        tick;
        chk("seq_sw_valid", 32'(out_valid), 32'd1);
        chk("seq_sw_word", out_instr, 32'h00512623);
        in_valid = 1'b0;
        tick;
        exp_emit += 2;
        chk("seq_drained", 32'(out_valid), 32'd0);
        chk("seq_emit", 32'(emit_count), 32'(exp_emit));

        // Backpressure: three ops, consumer stalled
        w1 = mk("b1", 2'b00, 5'd7, 5'd8, 5'd9, 3'd0, 7'h00, 13'h0, 1'b0, 32'h009403B3);
        w2 = mk("b2", 2'b01, 5'd4, 5'd3, 5'd0, 3'd0, 7'h00, 13'h0010, 1'b0, 32'h0101A203);
        w3 = mk("b3", 2'b11, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 13'h1FF8, 1'b0, 32'hFE208CE3);
        expq[0] = w1.exp; expq[1] = w2.exp; expq[2] = w3.exp;
        out_ready = 1'b0;
        drive(w1); tick;
        chk("bp_ready_after1", 32'(in_ready), 32'd1);
        drive(w2); tick;
        chk("bp_ready_full", 32'(in_ready), 32'd0);
        chk("bp_head", out_instr, w1.exp);
        drive(w3); tick;
        chk("bp_hold1", out_instr, w1.exp);
        chk("bp_still_full", 32'(in_ready), 32'd0);
        tick;
        chk("bp_hold2", out_instr, w1.exp);
        out_ready = 1'b1;
        idx = 0;
        for (int cyc = 0; cyc < 20 && idx < 3; cyc++) begin
            if (out_valid) begin
                chk("bp_order", out_instr, expq[idx]);
                idx++;
            end
            acc = in_valid && in_ready;
            tick;
            if (acc) in_valid = 1'b0;
        end
        checks++;
        if (idx != 3) begin
            failures++;
            $display("FAIL bp_timeout actual=%0d words expected=3", idx);
        end
        exp_emit += 3;
        chk("bp_empty", 32'(out_valid), 32'd0);
        chk("bp_emit", 32'(emit_count), 32'(exp_emit));

        // Rejects: out-of-range lw offset and odd branch offset
        drive(mk("lw_rej", 2'b01, 5'd1, 5'd1, 5'd0, 3'd0, 7'h00, 13'h0800, 1'b1, 32'h0));
        tick;
        chk("rej_lw_novalid", 32'(out_valid), 32'd0);
        drive(mk("beq_rej", 2'b11, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 13'h0005, 1'b1, 32'h0));
        tick;
        in_valid = 1'b0;
        exp_err += 2;
        chk("rej_novalid", 32'(out_valid), 32'd0);
        chk("rej_err2", 32'(err_count), 32'(exp_err));
        chk("rej_sticky", 32'(err_sticky), 32'd1);
        drive(mk("r_after", 2'b00, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 13'h0, 1'b0, 32'h0));
        tick;
        in_valid = 1'b0;
        chk("rej_then_r", out_instr, 32'h002081B3);
        tick;
        exp_emit++;

        // Table sweep: one op at a time, popped the cycle after it appears
        foreach (vecs[i]) begin
            drive(vecs[i]);
            tick;
            in_valid = 1'b0;
            if (!vecs[i].rej) begin
                chk({vecs[i].name, "_valid"}, 32'(out_valid), 32'd1);
                chk({vecs[i].name, "_word"}, out_instr, vecs[i].exp);
                tick;
                exp_emit++;
                chk({vecs[i].name, "_popped"}, 32'(out_valid), 32'd0);
                chk({vecs[i].name, "_emit"}, 32'(emit_count), 32'(exp_emit));
            end else begin
                exp_err++;
                chk({vecs[i].name, "_novalid"}, 32'(out_valid), 32'd0);
                chk({vecs[i].name, "_err"}, 32'(err_count), 32'(exp_err));
            end
        end

        // Reject coinciding with a pop: only the pop happens
        out_ready = 1'b0;
        drive(vecs[0]);
        tick;
        drive(mk("lw_rej2", 2'b01, 5'd1, 5'd1, 5'd0, 3'd0, 7'h00, 13'h0800, 1'b1, 32'h0));
        out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        exp_emit++; exp_err++;
        chk("rejpop_empty", 32'(out_valid), 32'd0);
        chk("rejpop_emit", 32'(emit_count), 32'(exp_emit));
        chk("rejpop_err", 32'(err_count), 32'(exp_err));

        // Error counter saturation
        drive(vecs[10]);
        repeat (300) tick;
        in_valid = 1'b0;
        chk("err_saturate", 32'(err_count), 32'hFF);
        chk("sat_novalid", 32'(out_valid), 32'd0);

        // Reset with a full FIFO discards everything
        out_ready = 1'b0;
        drive(vecs[1]); tick;
        drive(vecs[2]); tick;
        in_valid = 1'b0;
        chk("prerst_full", 32'(in_ready), 32'd0);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_in_ready", 32'(in_ready), 32'd1);
        chk("mrst_out_instr", out_instr, 32'h0);
        chk("mrst_emit", 32'(emit_count), 32'd0);
        chk("mrst_err", 32'(err_count), 32'd0);
        chk("mrst_sticky", 32'(err_sticky), 32'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick;
            chk("mrst_no_stale", 32'(out_valid), 32'd0);
        end
        chk("mrst_emit_hold", 32'(emit_count), 32'd0);
        drive(vecs[3]);
        tick;
        in_valid = 1'b0;
        chk("post_rst_word", out_instr, vecs[3].exp);
        tick;
        chk("post_rst_emit", 32'(emit_count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential RV32I instruction encoder: the producer side of the single-cycle core's instruction decode path. It accepts abstract operations (R-type, lw, sw, beq) over a valid/ready handshake, packs the fields into 32-bit RV32I instruction words, and streams them out through a 2-entry output FIFO. It feeds instruction memory preload and self-test generation, and its output is exactly the encoding the control unit and immediate generator consume.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation present on in_* fields
- in_ready  out  1  encoder can accept; transfer when in_valid && in_ready
- in_op  in  2  00 R-type, 01 lw, 10 sw, 11 beq
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_funct3  in  3  R-type funct3; ignored for lw/sw/beq
- in_funct7  in  7  R-type funct7; ignored otherwise
- in_imm  in  13  signed immediate; lw/sw byte offset, beq byte offset
- out_valid  out  1  out_instr holds a valid word
- out_ready  in  1  consumer accepts; transfer when out_valid && out_ready
- out_instr  out  32  encoded instruction (FIFO head)
- emit_count  out  16  instructions popped, wraps 0xFFFF -> 0x0000
- err_count  out  8  rejected ops, saturates at 0xFF
- err_sticky  out  1  set on first rejected op, cleared only by rst

## Operation
- Encoding, opcode in [6:0]:
  - R: {funct7, rs2, rs1, funct3, rd, 0110011}
  - lw: {imm[11:0], rs1, 010, rd, 0000011}
  - sw: {imm[11:5], rs2, rs1, 010, imm[4:0], 0100011}
  - beq: {imm[12], imm[10:5], rs2, rs1, 000, imm[4:1], imm[11], 1100011}
- Unused fields for an op (e.g. rs2 for lw) do not affect the output.
- Validation at accept:
  - lw/sw: reject if imm[12] != imm[11] (outside -2048..2047).
  - beq: reject if imm[0] == 1.
  - R-type: never rejected.
- Rejected op:
  - Handshake completes normally; nothing is pushed.
  - err_count increments (saturating); err_sticky sets.
- Accepted op: encoded word is pushed to the FIFO tail.
- FIFO: 2 entries with 2-bit occupancy count 0..2.
  - in_ready = (count != 2), registered-state derived; no combinational path from out_ready.
  - out_valid = (count != 0).
- Simultaneous push and pop, count 1: count stays 1, the old head leaves and the new word becomes head next cycle.
- Simultaneous push and pop, count 2: no push, since in_ready is low.
- Simultaneous push and pop, count 0: no pop; word lands, count 1.
- A rejected op with a simultaneous pop: pop only.
- emit_count increments on every out handshake.

## Timing
- Reset values: in_ready=1, out_valid=0, out_instr=0, emit_count=0, err_count=0, err_sticky=0, FIFO count=0.
- Latency: op accepted at edge N (FIFO empty) gives out_valid=1 with the word on out_instr after edge N, i.e. one cycle.
- out_instr is stable while out_valid && !out_ready.
- Throughput: 1 op/cycle when out_ready is held high.
- rst asserted mid-stream: at the next edge all FIFO contents are discarded and outputs return to reset values. No partial word is emitted.
- err_sticky and err_count update at the accepting edge, so they are visible the cycle after the reject.

## Test plan
- Reset, then R op funct7=0 funct3=0 rd=3 rs1=1 rs2=2 -> out_instr=0x002081B3 one cycle later; emit_count=1 after pop.
- lw rd=5 rs1=1 imm=8, then sw rs2=5 rs1=2 imm=12, out_ready=1 -> 0x0080A283 then 0x00512623 on consecutive cycles.
- beq rs1=1 rs2=2 imm=-8 (13'h1FF8) -> 0xFE208CE3.
- out_ready=0, push 3 ops -> in_ready drops after 2 accepted and out_instr is held. Raise out_ready -> all 3 emerge in order and emit_count=3.
- lw imm=2048 (13'h0800), then beq imm=5 -> no out_valid, err_count=2, err_sticky=1. A following valid R op still encodes correctly.
- Fill FIFO with 2 words, assert rst one cycle -> out_valid=0, in_ready=1, both counters 0, no stale word emitted afterwards.
